// File: rtl/vecmul_seq.sv
// vecmul_seq: streams a matrix row by row through an external pipelined
// vector multiplier against one latched vector, and returns one dot-product
// result per row, tagged with its row index.
// Optional feature: define VECMUL_SEQ_PERF_EN to add the perf_cycles
// busy-cycle counter output.
module vecmul_seq #(
    parameter int  VSIZE    = 4,
    parameter int  LAT      = 6,
    parameter int  MAX_ROWS = 16,
    localparam int RW       = $clog2(MAX_ROWS + 1),
    localparam int VW       = VSIZE * 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [RW-1:0] nrows,
    input  logic [VW-1:0] vec,
    output logic          rd_en,
    output logic [RW-1:0] rd_addr,
    input  logic [VW-1:0] row_data,
    output logic          vm_en,
    output logic [VW-1:0] vm_in1,
    output logic [VW-1:0] vm_in2,
    input  logic [31:0]   vm_result,
    output logic          out_valid,
    output logic [RW-1:0] out_idx,
    output logic [31:0]   out_data,
    output logic          busy,
    output logic          done
`ifdef VECMUL_SEQ_PERF_EN
    ,
    output logic [31:0]   perf_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   nrows_q, nrows_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [RW-1:0]   iss_cnt_q, iss_cnt_d;
    logic [RW-1:0]   out_cnt_q, out_cnt_d;
    logic            vm_en_q, vm_en_d;
    logic [LAT-1:0]  sr_q, sr_d;
    logic [RW-1:0]   nrows_clamped;

    // Oversized jobs are cut down to the largest supported row count.
    assign nrows_clamped = (nrows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : nrows;

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            nrows_q   <= '0;
            vec_q     <= '0;
            iss_cnt_q <= '0;
            out_cnt_q <= '0;
            vm_en_q   <= 1'b0;
            sr_q      <= '0;
        end else begin
            state_q   <= state_d;
            nrows_q   <= nrows_d;
            vec_q     <= vec_d;
            iss_cnt_q <= iss_cnt_d;
            out_cnt_q <= out_cnt_d;
            vm_en_q   <= vm_en_d;
            sr_q      <= sr_d;
        end
    end

    // Next-state logic: accept a job, issue every row, wait for all results.
    always_comb begin
        state_d   = state_q;
        nrows_d   = nrows_q;
        vec_d     = vec_q;
        iss_cnt_d = iss_cnt_q;
        out_cnt_d = out_cnt_q;
        if (out_valid) begin
            out_cnt_d = out_cnt_q + RW'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (nrows_clamped != '0) begin
                        nrows_d   = nrows_clamped;
                        vec_d     = vec;
                        iss_cnt_d = '0;
                        out_cnt_d = '0;
                        state_d   = ISSUE;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            ISSUE: begin
                iss_cnt_d = iss_cnt_q + RW'(1);
                if (iss_cnt_q == nrows_q - RW'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && (out_cnt_q == nrows_q - RW'(1))) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Issue tracking: multiplier strobe follows the read by one cycle, and a
    // LAT-deep tag line marks the cycle each result returns.
    always_comb begin
        vm_en_d = (state_q == ISSUE);
        sr_d    = '0;
        sr_d[0] = vm_en_q;
        for (int i = 1; i < LAT; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    // Output decode; data buses are held at zero whenever their strobe is low.
    always_comb begin
        rd_en     = (state_q == ISSUE);
        rd_addr   = rd_en ? iss_cnt_q : '0;
        vm_en     = vm_en_q;
        vm_in1    = vm_en_q ? row_data : '0;
        vm_in2    = vm_en_q ? vec_q : '0;
        out_valid = sr_q[LAT-1];
        out_idx   = out_valid ? out_cnt_q : '0;
        out_data  = out_valid ? vm_result : '0;
        busy      = (state_q != IDLE);
        done      = (state_q == FIN);
    end

`ifdef VECMUL_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating count of busy cycles, kept across jobs until reset.
    always_comb begin
        perf_d = perf_q;
        if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_vecmul_seq.sv
// Testbench for vecmul_seq: random row memories, vectors and multiplier
// results, checked cycle by cycle against a job-timeline reference model.
module tb_vecmul_seq;

    localparam int VSIZE    = 4;
    localparam int LAT      = 6;
    localparam int MAX_ROWS = 16;
    localparam int RW       = $clog2(MAX_ROWS + 1);
    localparam int VW       = VSIZE * 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [RW-1:0] nrows;
    logic [VW-1:0] vec;
    logic          rd_en;
    logic [RW-1:0] rd_addr;
    logic [VW-1:0] row_data;
    logic          vm_en;
    logic [VW-1:0] vm_in1;
    logic [VW-1:0] vm_in2;
    logic [31:0]   vm_result;
    logic          out_valid;
    logic [RW-1:0] out_idx;
    logic [31:0]   out_data;
    logic          busy;
    logic          done;
`ifdef VECMUL_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    always #5 clk = ~clk;

    vecmul_seq #(
        .VSIZE   (VSIZE),
        .LAT     (LAT),
        .MAX_ROWS(MAX_ROWS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .nrows    (nrows),
        .vec      (vec),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .row_data (row_data),
        .vm_en    (vm_en),
        .vm_in1   (vm_in1),
        .vm_in2   (vm_in2),
        .vm_result(vm_result),
        .out_valid(out_valid),
        .out_idx  (out_idx),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
`ifdef VECMUL_SEQ_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model of the current job
    logic          job_act = 1'b0;
    int            job_s, job_n, job_end;
    logic [VW-1:0] job_vec;
    logic [VW-1:0] mem [MAX_ROWS];
    int            perf_m = 0;

    // observations
    int ov_cnt = 0, last_idx = -1, first_ov = -1, last_done = -1, done_cnt = 0;
    logic          prev_rd = 1'b0;
    logic [RW-1:0] prev_addr = '0;

    typedef struct {
        int          due;
        logic [31:0] val;
    } res_t;
    res_t mq[$];

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VSIZE; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // integer dot product mod 2^32 stands in for the float multiplier
    function automatic logic [31:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [31:0] acc = '0;
        for (int i = 0; i < VSIZE; i++) acc += a[i*32 +: 32] * b[i*32 +: 32];
        return acc;
    endfunction

    task automatic all_zero(input string tag);
        chk({tag, "_rd_en"},     VW'(rd_en),     '0);
        chk({tag, "_rd_addr"},   VW'(rd_addr),   '0);
        chk({tag, "_vm_en"},     VW'(vm_en),     '0);
        chk({tag, "_vm_in1"},    vm_in1,         '0);
        chk({tag, "_vm_in2"},    vm_in2,         '0);
        chk({tag, "_out_valid"}, VW'(out_valid), '0);
        chk({tag, "_out_idx"},   VW'(out_idx),   '0);
        chk({tag, "_out_data"},  VW'(out_data),  '0);
        chk({tag, "_busy"},      VW'(busy),      '0);
        chk({tag, "_done"},      VW'(done),      '0);
`ifdef VECMUL_SEQ_PERF_EN
        chk({tag, "_perf"},      VW'(perf_cycles), '0);
`endif
    endtask

    // One clock cycle: drive inputs, update model, check outputs, advance.
    task automatic cycle_step(input logic st, input int nr);
        logic e_rd, e_vm, e_ov, e_done, e_busy;
        int   c, k;
        c = cyc;
        start    = st;
        nrows    = RW'(nr);
        vec      = rand_vec();
        row_data = (prev_rd && prev_addr < RW'(MAX_ROWS)) ? mem[prev_addr] : rand_vec();
        while (mq.size() > 0 && mq[0].due < c) void'(mq.pop_front());
        vm_result = $urandom;
        if (mq.size() > 0 && mq[0].due == c) vm_result = mq[0].val;

        if (st && !(job_act && c <= job_end)) begin
            job_act = 1'b1;
            job_s   = c;
            job_n   = (nr > MAX_ROWS) ? MAX_ROWS : nr;
            job_end = (job_n == 0) ? c + 1 : c + job_n + 2 + LAT;
            job_vec = vec;
            for (int i = 0; i < MAX_ROWS; i++) mem[i] = rand_vec();
            ov_cnt   = 0;
            last_idx = -1;
            first_ov = -1;
        end

        e_rd   = job_act && c >= job_s + 1 && c <= job_s + job_n;
        e_vm   = job_act && c >= job_s + 2 && c <= job_s + job_n + 1;
        e_ov   = job_act && c >= job_s + 2 + LAT && c <= job_s + job_n + 1 + LAT;
        e_done = job_act && c == job_end;
        e_busy = job_act && c >= job_s + 1 && c <= job_end;

        #1;
        chk("rd_en",     VW'(rd_en),     VW'(e_rd));
        chk("vm_en",     VW'(vm_en),     VW'(e_vm));
        chk("out_valid", VW'(out_valid), VW'(e_ov));
        chk("done",      VW'(done),      VW'(e_done));
        chk("busy",      VW'(busy),      VW'(e_busy));
        chk("vm_in1",    vm_in1, e_vm ? mem[c - job_s - 2] : '0);
        chk("vm_in2",    vm_in2, e_vm ? job_vec : '0);
        if (e_rd) chk("rd_addr", VW'(rd_addr), VW'(c - job_s - 1));
        if (e_ov) begin
            k = c - job_s - 2 - LAT;
            chk("out_idx",  VW'(out_idx),  VW'(k));
            chk("out_data", VW'(out_data), VW'(dot(mem[k], job_vec)));
        end
`ifdef VECMUL_SEQ_PERF_EN
        chk("perf_cycles", VW'(perf_cycles), VW'(perf_m));
`endif
        if (e_busy) perf_m++;
        if (done) begin
            done_cnt++;
            last_done = c;
        end
        if (out_valid) begin
            if (ov_cnt == 0) first_ov = c;
            ov_cnt++;
            last_idx = int'(out_idx);
        end
        prev_rd   = rd_en;
        prev_addr = rd_addr;
        if (vm_en) mq.push_back('{due: c + LAT, val: dot(vm_in1, vm_in2)});
        if (job_act && c >= job_end) job_act = 1'b0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input logic noisy);
        int b = 0;
        while (job_act && b < 200) begin
            if (noisy) cycle_step(1'($urandom_range(0, 1)), $urandom_range(0, 31));
            else       cycle_step(1'b0, 0);
            b++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle_step(1'b0, 0);
    endtask

    task automatic mid_reset();
        start   = 1'b0;
        rst_n   = 1'b0;
        #1;
        all_zero("rst_now");
        job_act = 1'b0;
        prev_rd = 1'b0;
        perf_m  = 0;
        mq.delete();
        @(posedge clk);
        #1;
        cyc++;
        all_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        int s, d0;
        rst_n     = 1'b0;
        start     = 1'b0;
        nrows     = '0;
        vec       = '0;
        row_data  = '0;
        vm_result = '0;
        repeat (2) @(posedge clk);
        #1;
        all_zero("reset");
        rst_n = 1'b1;

        // 3-row job, checked against absolute cycle numbers too
        s = cyc;
        cycle_step(1'b1, 3);
        drain(1'b0);
        chk("s1_first_ov", VW'(first_ov - s),  VW'(8));
        chk("s1_done_at",  VW'(last_done - s), VW'(11));
        chk("s1_ov_cnt",   VW'(ov_cnt),        VW'(3));
        idle(2);

        // empty job
        d0 = done_cnt;
        s  = cyc;
        cycle_step(1'b1, 0);
        drain(1'b0);
        chk("s2_done_at",  VW'(last_done - s),  VW'(1));
        chk("s2_done_cnt", VW'(done_cnt - d0),  VW'(1));
        idle(1);

        // start re-pulsed while busy
        d0 = done_cnt;
        cycle_step(1'b1, 3);
        idle(3);
        cycle_step(1'b1, 5);
        drain(1'b0);
        chk("s3_done_cnt", VW'(done_cnt - d0), VW'(1));
        chk("s3_ov_cnt",   VW'(ov_cnt),        VW'(3));
        idle(1);

        // oversized job is clamped
        cycle_step(1'b1, MAX_ROWS + 5);
        drain(1'b0);
        chk("s4_ov_cnt",   VW'(ov_cnt),   VW'(MAX_ROWS));
        chk("s4_last_idx", VW'(last_idx), VW'(MAX_ROWS - 1));
        idle(1);

        // random jobs with spurious starts while busy
        for (int j = 0; j < 8; j++) begin
            cycle_step(1'b1, $urandom_range(0, MAX_ROWS + 3));
            drain(1'b1);
            idle($urandom_range(0, 2));
        end

        // reset in the middle of a 3-row job
        cycle_step(1'b1, 3);
        idle(4);
        mid_reset();
        idle(12);

        // two 3-row jobs after reset
        cycle_step(1'b1, 3);
        drain(1'b0);
        chk("s5_first_idx_ok", VW'(ov_cnt), VW'(3));
        cycle_step(1'b1, 3);
        drain(1'b0);
        idle(1);
`ifdef VECMUL_SEQ_PERF_EN
        chk("perf_two_jobs", VW'(perf_cycles), VW'(22));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
